// File: rtl/pc_unit_ras.sv
// ============================================================================
//  Module   : pc_unit_ras
//  Purpose  : Program counter with conditional branch, trap vector, alignment
//             masking and a circular return-address stack for call/return.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_unit_ras #(
    parameter int unsigned         WIDTH        = 32,
    parameter logic [WIDTH-1:0]    RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]    TRAP_VECTOR  = 32'h0000_0080,
    parameter int unsigned         RAS_DEPTH    = 4,
    parameter int unsigned         ALIGN        = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_write,
    input  logic             branch_en,
    input  logic [1:0]       branch_cond,
    input  logic             zero,
    input  logic             negative,
    input  logic [WIDTH-1:0] pc_in,
    input  logic             call,
    input  logic             ret,
    input  logic [WIDTH-1:0] link_addr,
    input  logic             trap,
    input  logic             err_clr,
    output logic [WIDTH-1:0] pc_addr,
    output logic             branch_taken,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow
);

    localparam int unsigned      c_PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned      c_CNT_W      = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] c_ALIGN_MASK = {WIDTH{1'b1}} << ALIGN;

    localparam logic [1:0] c_COND_EQ = 2'b00;
    localparam logic [1:0] c_COND_NE = 2'b01;
    localparam logic [1:0] c_COND_LT = 2'b10;
    localparam logic [1:0] c_COND_GE = 2'b11;

    logic [WIDTH-1:0]   r_pc;
    logic               r_branch_taken;
    logic               r_overflow;
    logic               r_underflow;
    logic [c_CNT_W-1:0] r_count;
    logic [c_PTR_W-1:0] r_top;
    logic [WIDTH-1:0]   r_ras [RAS_DEPTH];

    logic               w_cond_true;
    logic [WIDTH-1:0]   w_pc_nxt;
    logic               w_branch_taken_nxt;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_PTR_W-1:0] w_top_nxt;
    logic               w_push;
    logic               w_ovf_set;
    logic               w_unf_set;

    always_comb begin
        w_cond_true = 1'b0;
        case (branch_cond)
            c_COND_EQ: w_cond_true = zero;
            c_COND_NE: w_cond_true = ~zero;
            c_COND_LT: w_cond_true = negative;
            c_COND_GE: w_cond_true = ~negative;
            default:   w_cond_true = 1'b0;
        endcase
    end

    // Priority chain: trap > ret > call > branch > plain write > hold.
    always_comb begin
        w_pc_nxt           = r_pc;
        w_branch_taken_nxt = 1'b0;
        w_count_nxt        = r_count;
        w_top_nxt          = r_top;
        w_push             = 1'b0;
        w_ovf_set          = 1'b0;
        w_unf_set          = 1'b0;
        if (trap) begin
            w_pc_nxt = TRAP_VECTOR & c_ALIGN_MASK;
        end else if (ret) begin
            if (r_count != '0) begin
                w_pc_nxt    = r_ras[r_top] & c_ALIGN_MASK;
                w_top_nxt   = r_top - 1'b1;
                w_count_nxt = r_count - 1'b1;
            end else begin
                w_unf_set = 1'b1;
            end
        end else if (call && pc_write) begin
            w_pc_nxt  = pc_in & c_ALIGN_MASK;
            w_push    = 1'b1;
            w_top_nxt = r_top + 1'b1;
            if (r_count == c_DEPTH) begin
                w_ovf_set = 1'b1;
            end else begin
                w_count_nxt = r_count + 1'b1;
            end
        end else if (branch_en) begin
            w_branch_taken_nxt = w_cond_true;
            if (w_cond_true) begin
                w_pc_nxt = pc_in & c_ALIGN_MASK;
            end
        end else if (pc_write) begin
            w_pc_nxt = pc_in & c_ALIGN_MASK;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc           <= RESET_VECTOR;
            r_branch_taken <= 1'b0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_count        <= '0;
            r_top          <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else begin
            r_pc           <= w_pc_nxt;
            r_branch_taken <= w_branch_taken_nxt;
            r_count        <= w_count_nxt;
            r_top          <= w_top_nxt;
            // A new error on the same edge as err_clr keeps the flag set.
            r_overflow     <= w_ovf_set | (r_overflow  & ~err_clr);
            r_underflow    <= w_unf_set | (r_underflow & ~err_clr);
            if (w_push) begin
                r_ras[w_top_nxt] <= link_addr;
            end
        end
    end

    assign pc_addr       = r_pc;
    assign branch_taken  = r_branch_taken;
    assign ras_empty     = (r_count == '0);
    assign ras_full      = (r_count == c_DEPTH);
    assign ras_overflow  = r_overflow;
    assign ras_underflow = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_pc_unit_ras.sv
// ============================================================================
//  Module   : tb_pc_unit_ras
//  Purpose  : Directed vector bench for pc_unit_ras.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_unit_ras;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_write = 1'b0;
    logic        branch_en = 1'b0;
    logic [1:0]  branch_cond = 2'b00;
    logic        zero = 1'b0;
    logic        negative = 1'b0;
    logic [31:0] pc_in = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] link_addr = '0;
    logic        trap = 1'b0;
    logic        err_clr = 1'b0;

    logic [31:0] pc_addr;
    logic        branch_taken, ras_empty, ras_full, ras_overflow, ras_underflow;
    logic [31:0] rv_pc_addr;
    logic        rv_branch_taken, rv_ras_empty, rv_ras_full, rv_ras_overflow, rv_ras_underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_unit_ras dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch_en(branch_en),
        .branch_cond(branch_cond), .zero(zero), .negative(negative), .pc_in(pc_in),
        .call(call), .ret(ret), .link_addr(link_addr), .trap(trap), .err_clr(err_clr),
        .pc_addr(pc_addr), .branch_taken(branch_taken), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
    );

    pc_unit_ras #(.RESET_VECTOR(32'h100)) dut_rv (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch_en(branch_en),
        .branch_cond(branch_cond), .zero(zero), .negative(negative), .pc_in(pc_in),
        .call(call), .ret(ret), .link_addr(link_addr), .trap(trap), .err_clr(err_clr),
        .pc_addr(rv_pc_addr), .branch_taken(rv_branch_taken), .ras_empty(rv_ras_empty),
        .ras_full(rv_ras_full), .ras_overflow(rv_ras_overflow), .ras_underflow(rv_ras_underflow)
    );

    typedef struct {
        logic        pw, be;
        logic [1:0]  cond;
        logic        z, n;
        logic [31:0] pin;
        logic        cl, rt;
        logic [31:0] link;
        logic        tr, clr;
        logic [31:0] epc;
        logic        ebt, eempty, efull, eovf, eunf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (vector %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_outputs(input int idx, input logic [31:0] epc, input logic ebt,
                                 input logic eempty, input logic efull,
                                 input logic eovf, input logic eunf);
        chk("pc_addr",       idx, pc_addr,               epc);
        chk("branch_taken",  idx, {31'b0, branch_taken},  {31'b0, ebt});
        chk("ras_empty",     idx, {31'b0, ras_empty},     {31'b0, eempty});
        chk("ras_full",      idx, {31'b0, ras_full},      {31'b0, efull});
        chk("ras_overflow",  idx, {31'b0, ras_overflow},  {31'b0, eovf});
        chk("ras_underflow", idx, {31'b0, ras_underflow}, {31'b0, eunf});
    endtask

    initial begin
        //        pw be cond   z  n  pin           cl rt link       tr clr  epc           bt em fu ov un
        tbl.push_back('{0, 1, 2'b00, 1, 0, 32'h40,    0, 0, 32'h0,   0, 0, 32'h40,    1, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 2'b01, 1, 0, 32'h80,    0, 0, 32'h0,   0, 0, 32'h40,    0, 1, 0, 0, 0});
        tbl.push_back('{1, 1, 2'b10, 0, 0, 32'h99,    0, 0, 32'h0,   0, 0, 32'h40,    0, 1, 0, 0, 0});
        tbl.push_back('{0, 1, 2'b11, 0, 0, 32'h53,    0, 0, 32'h0,   0, 0, 32'h50,    1, 1, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h1237,  0, 0, 32'h0,   0, 0, 32'h1234,  0, 1, 0, 0, 0});
        // nested call / return
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h200,   1, 0, 32'h14,  0, 0, 32'h200,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h300,   1, 0, 32'h204, 0, 0, 32'h300,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h400,   1, 0, 32'h304, 0, 0, 32'h400,   0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h304,   0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h204,   0, 0, 0, 0, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h14,    0, 1, 0, 0, 0});
        // overflow: five pushes into a four-deep stack
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h500,   1, 0, 32'h04,  0, 0, 32'h500,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h600,   1, 0, 32'h08,  0, 0, 32'h600,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h700,   1, 0, 32'h0C,  0, 0, 32'h700,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h800,   1, 0, 32'h10,  0, 0, 32'h800,   0, 0, 1, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h900,   1, 0, 32'h14,  0, 0, 32'h900,   0, 0, 1, 1, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h14,    0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h10,    0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h0C,    0, 0, 0, 1, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h08,    0, 1, 0, 1, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h08,    0, 1, 0, 1, 1});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 0, 32'h0,   0, 1, 32'h08,    0, 1, 0, 0, 0});
        // priority corners
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h600,   1, 0, 32'h20,  0, 0, 32'h600,   0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h700,   1, 1, 32'h30,  1, 0, 32'h80,    0, 0, 0, 0, 0});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h900,   1, 1, 32'h40,  0, 0, 32'h20,    0, 1, 0, 0, 0});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 0, 32'h20,    0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h0,     0, 1, 32'h0,   0, 1, 32'h20,    0, 1, 0, 0, 1});
        tbl.push_back('{0, 0, 2'b00, 0, 0, 32'h300,   1, 0, 32'h50,  0, 0, 32'h20,    0, 1, 0, 0, 1});
        tbl.push_back('{0, 1, 2'b00, 1, 0, 32'h44,    0, 0, 32'h0,   1, 0, 32'h80,    0, 1, 0, 0, 1});
        tbl.push_back('{1, 0, 2'b00, 0, 0, 32'h1000,  0, 0, 32'h0,   0, 0, 32'h1000,  0, 1, 0, 0, 1});

        // Reset held across a clock edge, then released away from the edge.
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_outputs(-1, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rv_pc_addr", -1, rv_pc_addr, 32'h100);

        for (int i = 0; i < tbl.size(); i++) begin
            pc_write    = tbl[i].pw;
            branch_en   = tbl[i].be;
            branch_cond = tbl[i].cond;
            zero        = tbl[i].z;
            negative    = tbl[i].n;
            pc_in       = tbl[i].pin;
            call        = tbl[i].cl;
            ret         = tbl[i].rt;
            link_addr   = tbl[i].link;
            trap        = tbl[i].tr;
            err_clr     = tbl[i].clr;
            @(posedge clk);
            #1;
            check_outputs(i, tbl[i].epc, tbl[i].ebt, tbl[i].eempty,
                          tbl[i].efull, tbl[i].eovf, tbl[i].eunf);
        end

        // Asynchronous reset mid-cycle: outputs must drop without a clock edge.
        pc_write = 1'b0; branch_en = 1'b0; call = 1'b0; ret = 1'b0;
        trap = 1'b0; err_clr = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check_outputs(100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rv_pc_addr", 100, rv_pc_addr, 32'h100);
        @(negedge clk);
        reset = 1'b1;
        pc_write = 1'b1;
        pc_in = 32'h2222;
        @(posedge clk);
        #1;
        chk("pc_after_reset", 101, pc_addr, 32'h2220);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program counter for the multicycle CPU. It replaces the single-mode PC register and adds:
- four branch-condition modes evaluated from ALU flags
- a trap vector
- address alignment masking
- a circular return-address stack (RAS) of configurable depth for call/return

It sits between the PCSource mux and instruction memory, and is driven by the control FSM.

Parameters:
WIDTH, 32, PC and address width in bits
RESET_VECTOR, 0, PC value after reset
TRAP_VECTOR, 32'h0000_0080, PC value loaded on trap
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)
ALIGN, 2, number of low PC bits forced to 0 on every load

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
pc_write  in  1  unconditional PC update enable (non-branch cycles)
branch_en  in  1  branch instruction in this cycle
branch_cond  in  2  00 EQ, 01 NE, 10 LT (signed), 11 GE (signed)
zero  in  1  ALU zero flag
negative  in  1  ALU sign flag (signed compare result)
pc_in  in  WIDTH  next-PC candidate from PCSource mux
call  in  1  push link_addr and jump to pc_in
ret  in  1  pop RAS top into PC
link_addr  in  WIDTH  return address to push (PC+4, computed externally)
trap  in  1  force PC to TRAP_VECTOR
err_clr  in  1  clear sticky RAS error flags
pc_addr  out  WIDTH  current PC
branch_taken  out  1  registered: last-cycle branch was taken
ras_empty  out  1  RAS holds 0 entries
ras_full  out  1  RAS holds RAS_DEPTH entries
ras_overflow  out  1  sticky: push while full
ras_underflow  out  1  sticky: pop while empty

Behaviour:
- Reset (reset=0, asynchronous):
  - pc_addr=RESET_VECTOR, branch_taken=0, ras_overflow=0, ras_underflow=0
  - RAS count=0, top pointer=0, all entries 0, so ras_empty=1 and ras_full=0
  - Reset mid-push/pop discards the operation.
- Condition: cond_true is EQ: zero; NE: !zero; LT: negative; GE: !negative.
- Per-edge priority (highest first):
  1. trap: pc<=TRAP_VECTOR. RAS unchanged. branch_taken<=0. All other inputs ignored.
  2. ret: if count>0, pc<=RAS[top] (masked), top<=top-1 mod RAS_DEPTH, count-=1. If count==0, pc unchanged and ras_underflow<=1. A simultaneous call is ignored.
  3. call (requires pc_write=1; ignored otherwise): pc<=pc_in, RAS[top+1]<=link_addr, top<=top+1 mod RAS_DEPTH.
     - If not full, count+=1.
     - If full, the oldest entry is overwritten, count stays RAS_DEPTH, ras_overflow<=1.
  4. branch_en=1: pc<=pc_in if cond_true, else pc holds. pc_write is ignored in this cycle. branch_taken<=cond_true.
  5. pc_write=1: pc<=pc_in.
  6. Otherwise pc holds.
- branch_taken is 0 in every cycle where case 4 does not apply.
- Every value loaded into pc has bits [ALIGN-1:0] cleared; with ALIGN=0 no masking.
- Latency: pc_addr reflects a load one clk edge after the request is sampled. Combinational paths to pc_addr are prohibited.
- ras_empty and ras_full are decoded from the registered count, so they are valid in the cycle after the push/pop.
- err_clr clears both sticky flags on the edge. If a new error occurs on the same edge, the set wins.
- Address arithmetic is modulo 2^WIDTH. The RAS pointer wraps modulo RAS_DEPTH.

Test Plan:
1. Reset release: hold reset=0, pulse clk, release → pc_addr=0, ras_empty=1, flags 0. With RESET_VECTOR=32'h100 → pc_addr=32'h100.
2. Branch modes: zero=1 with EQ and pc_in=32'h40 → pc=32'h40, branch_taken=1. Then zero=1 with NE → pc holds, branch_taken=0. With branch_en=1 and pc_write=1 and cond false → pc holds.
3. Call/return nesting:
   - Three calls (pc_in 32'h200/300/400, link_addr 32'h14/204/304) then three rets → pc sequence 32'h304, 32'h204, 32'h14.
   - ras_empty=1 at end, no error flags.
4. RAS overflow: RAS_DEPTH=4, five calls with link 1..5 (×4) → ras_full=1, ras_overflow=1. Five rets return 32'h14, 32'h10, 32'h0C, 32'h08, then underflow with pc held and ras_underflow=1.
5. Priority: trap+ret+call same edge → pc=32'h80, RAS count unchanged. ret+call same edge → ret only. err_clr with concurrent underflow → flag stays 1.
6. Alignment and async reset: pc_write with pc_in=32'h1237 → pc=32'h1234. Assert reset between edges mid-sequence → pc_addr=RESET_VECTOR immediately, without waiting for a clk edge.
